// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates from a positive-polarity hsync/vsync
// video stream and checks that the timing is stable before flagging pixels valid.
//   clk1485      pixel clock
//   rst_n        synchronous reset, active-high (asserted = 1)
//   h_sync/v_sync  sync inputs, positive polarity
//   rgb_in       pixel {R,G,B} 4 bits each
//   x/y/rgb_out  coordinates and pixel of the current beat (2 cycles after input)
//   pix_valid    active pixel while locked
//   frame_start  pulse on the x=0,y=0 valid beat
//   locked       timing stable
//   h_total/v_total  last measured line length (cycles) / frame length (lines)
//   sync_err     pulse on loss of lock or hsync timeout
module vga_sync_rx #(
    parameter int unsigned H_OFFSET    = 192,
    parameter int unsigned H_ACTIVE    = 1920,
    parameter int unsigned V_OFFSET    = 41,
    parameter int unsigned V_ACTIVE    = 1080,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk1485,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [11:0] rgb_in,
    output logic [13:0] x,
    output logic [13:0] y,
    output logic [11:0] rgb_out,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [13:0] h_total,
    output logic [13:0] v_total,
    output logic        sync_err
);

    localparam int unsigned CW  = 14;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = 12;
    localparam int unsigned MW  = 4;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   H_LO    = CW1'(H_OFFSET);
    localparam logic [CW:0]   H_HI    = CW1'(H_OFFSET + H_ACTIVE);
    localparam logic [CW:0]   V_LO    = CW1'(V_OFFSET);
    localparam logic [CW:0]   V_HI    = CW1'(V_OFFSET + V_ACTIVE);
    localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // input sample stage
    logic          hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [PW-1:0] rgb_s_q;

    // timing recovery state
    logic [CW-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic          arm_q, arm_d;
    logic          line_seen_q, line_seen_d;
    logic          hvalid_q, hvalid_d, vvalid_q, vvalid_d;
    logic          line_ok_q, line_ok_d;
    logic [MW-1:0] match_q, match_d;
    logic [CW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;

    // output stage
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [PW-1:0] rgb_o_q, rgb_o_d;
    logic          pv_q, pv_d, fs_q, fs_d, locked_q, locked_d, err_q, err_d;

    // combinational helpers
    logic          hs_edge, vs_edge, fs_line, timeout, go_search;
    logic          line_chk, line_bad, frame_chk, frame_good, active;
    logic [CW-1:0] line_len, frame_len;
    logic [CW:0]   hx, lx;

    // counters, measurement and lock FSM next state
    always_comb begin
        hs_edge    = hs_q & ~hs_prev_q;
        vs_edge    = vs_q & ~vs_prev_q;
        // a vsync edge in the same sample as an hsync edge starts the frame on that line
        fs_line    = hs_edge & (arm_q | vs_edge);

        hcnt_d     = hs_edge ? '0 : ((hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CW'(1));
        lcnt_d     = fs_line ? '0 :
                     (hs_edge ? ((lcnt_q == CNT_MAX) ? CNT_MAX : lcnt_q + CW'(1)) : lcnt_q);
        // fires exactly once, on the sample where hcnt reaches saturation
        timeout    = ~hs_edge & (hcnt_q == CNT_MAX - CW'(1));

        line_len   = hcnt_q + CW'(1);
        frame_len  = lcnt_q + CW'(1);
        // the line/frame before the first edge seen is partial and never measured
        line_chk   = hs_edge & line_seen_q;
        line_bad   = line_chk & hvalid_q & (line_len != h_total_q);
        frame_chk  = fs_line & (state_q != ST_SEARCH);
        frame_good = line_ok_q & ~line_bad & (~vvalid_q | (frame_len == v_total_q));

        state_d     = state_q;
        match_d     = match_q;
        err_d       = 1'b0;
        go_search   = 1'b0;
        arm_d       = fs_line ? 1'b0 : (vs_edge ? 1'b1 : arm_q);
        line_seen_d = line_seen_q | hs_edge;
        h_total_d   = line_chk ? line_len : h_total_q;
        hvalid_d    = hvalid_q | line_chk;
        v_total_d   = frame_chk ? frame_len : v_total_q;
        vvalid_d    = vvalid_q | frame_chk;
        line_ok_d   = fs_line ? 1'b1 : (line_ok_q & ~line_bad);

        case (state_q)
            ST_SEARCH: begin
                if (fs_line) begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                end
            end
            ST_MEASURE: begin
                if (frame_chk) begin
                    if (frame_good) begin
                        match_d = match_q + MW'(1);
                        if (match_q + MW'(1) == LOCK_N) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_bad | (frame_chk & (frame_len != v_total_q))) begin
                    state_d   = ST_SEARCH;
                    err_d     = 1'b1;
                    go_search = 1'b1;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                go_search = 1'b1;
            end
        endcase

        if (timeout) begin
            err_d     = (state_q == ST_LOCKED);
            state_d   = ST_SEARCH;
            go_search = 1'b1;
        end

        // restart measurement from scratch; reported totals are kept
        if (go_search) begin
            line_seen_d = 1'b0;
            hvalid_d    = 1'b0;
            vvalid_d    = 1'b0;
            match_d     = '0;
        end

        // output stage: pixels are valid only while lock holds through this sample
        hx       = {1'b0, hcnt_d};
        lx       = {1'b0, lcnt_d};
        active   = (hx >= H_LO) && (hx < H_HI) && (lx >= V_LO) && (lx < V_HI);
        pv_d     = active & (state_q == ST_LOCKED) & (state_d == ST_LOCKED);
        x_d      = pv_d ? (hcnt_d - CW'(H_OFFSET)) : '0;
        y_d      = pv_d ? (lcnt_d - CW'(V_OFFSET)) : '0;
        rgb_o_d  = pv_d ? rgb_s_q : '0;
        fs_d     = pv_d & (hcnt_d == CW'(H_OFFSET)) & (lcnt_d == CW'(V_OFFSET));
        locked_d = (state_q == ST_LOCKED);
    end

    // state and pipeline registers
    always_ff @(posedge clk1485) begin
        if (rst_n) begin
            state_q     <= ST_SEARCH;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            rgb_s_q     <= '0;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            arm_q       <= 1'b0;
            line_seen_q <= 1'b0;
            hvalid_q    <= 1'b0;
            vvalid_q    <= 1'b0;
            line_ok_q   <= 1'b0;
            match_q     <= '0;
            h_total_q   <= '0;
            v_total_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rgb_o_q     <= '0;
            pv_q        <= 1'b0;
            fs_q        <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_q        <= h_sync;
            vs_q        <= v_sync;
            hs_prev_q   <= hs_q;
            vs_prev_q   <= vs_q;
            rgb_s_q     <= rgb_in;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            arm_q       <= arm_d;
            line_seen_q <= line_seen_d;
            hvalid_q    <= hvalid_d;
            vvalid_q    <= vvalid_d;
            line_ok_q   <= line_ok_d;
            match_q     <= match_d;
            h_total_q   <= h_total_d;
            v_total_q   <= v_total_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rgb_o_q     <= rgb_o_d;
            pv_q        <= pv_d;
            fs_q        <= fs_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign rgb_out     = rgb_o_q;
    assign pix_valid   = pv_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign sync_err    = err_q;

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_OFFSET, default 192: cycles from the hsync rising edge to the first active pixel (sync 44 + back porch 148).
REQ-002 Parameter H_ACTIVE, default 1920: active pixels per line.
REQ-003 Parameter V_OFFSET, default 41: lines from the frame-start line to the first active line (sync 5 + back porch 36).
REQ-004 Parameter V_ACTIVE, default 1080: active lines per frame.
REQ-005 Parameter LOCK_FRAMES, default 2: consecutive matching frames required for lock (range 1..15).
REQ-006 clk1485  in  1  pixel clock; all logic on the rising edge; one clock domain only.
REQ-007 rst_n  in  1  synchronous reset, active-high despite the name (asserted = 1).
REQ-008 h_sync, v_sync  in  1 each  sync inputs, positive polarity, synchronous to clk1485.
REQ-009 rgb_in  in  12  pixel {R[3:0],G[3:0],B[3:0]}, sampled every cycle.
REQ-010 x, y  out  14 each  recovered coordinates of the current rgb_out.
REQ-011 rgb_out  out  12  delayed pixel; 0 when pix_valid=0.
REQ-012 pix_valid  out  1  rgb_out/x/y hold an active pixel and locked=1.
REQ-013 frame_start  out  1  one-cycle pulse coinciding with the pix_valid beat x=0,y=0.
REQ-014 locked  out  1  timing stable.
REQ-015 h_total, v_total  out  14 each  last measured line length (cycles) and frame length (lines).
REQ-016 sync_err  out  1  one-cycle pulse on loss of lock or timeout.

Function
REQ-017 Inputs are registered once; an hsync edge is a sample with h_sync=1 whose predecessor had h_sync=0; likewise for vsync.
REQ-018 hcnt: 0 on an hsync-edge sample, +1 per subsequent sample, saturating at 16383.
REQ-019 A vsync edge arms frame start; the next hsync edge (same sample included) sets lcnt=0; each later hsync edge increments lcnt, saturating at 16383.
REQ-020 Sample is active iff H_OFFSET <= hcnt < H_OFFSET+H_ACTIVE and V_OFFSET <= lcnt < V_OFFSET+V_ACTIVE; x=hcnt-H_OFFSET, y=lcnt-V_OFFSET.
REQ-021 Latency: rgb_out, x, y, pix_valid, frame_start appear exactly 2 cycles after the corresponding rgb_in sample on the pins.
REQ-022 On every hsync edge, h_total <= hcnt+1 of the ending line (cycles between edges); on every frame-start line, v_total <= lcnt+1 of the ending frame.
REQ-023 The first partial line/frame after reset or after entering SEARCH updates neither h_total, v_total nor match counting.
REQ-024 FSM states SEARCH, MEASURE, LOCKED; reset -> SEARCH.
REQ-025 SEARCH: on the first frame start -> MEASURE; match_cnt=0.
REQ-026 MEASURE: at each frame start, if the completed frame's line count equals v_total and every line equalled the previous line length, match_cnt+1, else match_cnt=0; match_cnt reaching LOCK_FRAMES -> LOCKED.
REQ-027 LOCKED: any line length != h_total or frame length != v_total -> pulse sync_err, -> SEARCH in the same cycle; locked drops on the next cycle.
REQ-028 Timeout: hcnt saturating (no hsync edge for 16383 cycles) in any state -> SEARCH; sync_err pulses if previously LOCKED.
REQ-029 Simultaneous hsync and vsync edges in one sample: that hsync edge itself starts the frame (lcnt=0).
REQ-030 pix_valid is 0 whenever locked=0, including the pipeline beats in flight when lock is lost.

Reset
REQ-031 rst_n=1 for one or more cycles forces: state SEARCH, counters 0, x=y=0, rgb_out=0, pix_valid=0, frame_start=0, locked=0, h_total=v_total=0, sync_err=0.
REQ-032 Reset mid-frame discards all measurements; relock requires a full SEARCH/MEASURE sequence.

Verification
REQ-033 Standard 1080p stream (2200x1125), LOCK_FRAMES=2 -> locked=1 during the 3rd full frame; h_total=2200, v_total=1125; 2,073,600 pix_valid beats per frame.
REQ-034 Pixel at hcnt=192, lcnt=41 carrying rgb_in=12'hABC -> 2 cycles later: x=0, y=0, rgb_out=12'hABC, frame_start=1; last beat x=1919, y=1079.
REQ-035 While locked, one line shortened to 2199 cycles -> sync_err one-cycle pulse, locked=0 next cycle, pix_valid=0 immediately; relock after 2 good frames.
REQ-036 h_sync held low 20000 cycles while locked -> sync_err at hcnt saturation, state SEARCH, h_total unchanged at 2200.
REQ-037 rst_n=1 for 1 cycle mid-frame while locked -> next cycle all outputs at reset values; locked returns only after the full relock sequence.
REQ-038 vsync and hsync edges in the same sample -> that line is lcnt=0; the first active line is the 41st hsync edge after it.
